// File: rtl/gemm_mac_sched_if.sv
// Control/handshake bundle between gemm_mac_sched (master) and the GEMM top/datapath (slave).
// Index widths follow the matrix dimensions; the instantiating module must use the same dimensions.
interface gemm_mac_sched_if #(
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4,
  parameter int MATRIX_ADJUST = 4
);
  localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int CW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
  localparam int KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1;

  logic          istart;
  logic          iready;
  logic [RW-1:0] orow;
  logic [CW-1:0] ocol;
  logic [KW-1:0] ok;
  logic          omac_valid;
  logic          oacc_clr;
  logic          oscale_valid;
  logic          owb_en;
  logic          obusy;
  logic          odone;
  logic [31:0]   operf_cycles;
  logic [31:0]   operf_stalls;

  modport master (
    input  istart, iready,
    output orow, ocol, ok, omac_valid, oacc_clr, oscale_valid, owb_en,
           obusy, odone, operf_cycles, operf_stalls
  );

  modport slave (
    output istart, iready,
    input  orow, ocol, ok, omac_valid, oacc_clr, oscale_valid, owb_en,
           obusy, odone, operf_cycles, operf_stalls
  );
endinterface

// File: rtl/gemm_mac_sched.sv
// GEMM sequencer: walks (row, col, k) row-major, issues MAC ops under valid/ready, then scale + writeback.
// Optional busy/stall counters are built only when GEMM_SCHED_PERF_EN is defined.
module gemm_mac_sched #(
  parameter int DATA_WIDTH    = 64,
  parameter int MATRIX_WIDTH  = 4,
  parameter int MATRIX_HEIGHT = 4,
  parameter int MATRIX_ADJUST = 4
) (
  input  logic             iclk,
  input  logic             irst,
  gemm_mac_sched_if.master bus
);
  localparam int RW = (MATRIX_HEIGHT > 1) ? $clog2(MATRIX_HEIGHT) : 1;
  localparam int CW = (MATRIX_WIDTH  > 1) ? $clog2(MATRIX_WIDTH)  : 1;
  localparam int KW = (MATRIX_ADJUST > 1) ? $clog2(MATRIX_ADJUST) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(MATRIX_HEIGHT - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(MATRIX_WIDTH - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(MATRIX_ADJUST - 1);

  if (DATA_WIDTH < 1 || MATRIX_WIDTH < 1 || MATRIX_HEIGHT < 1 || MATRIX_ADJUST < 1) begin : g_param_check
    $error("gemm_mac_sched: all dimensions and DATA_WIDTH must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_SCALE,
    S_WB,
    S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] row_reg, row_next;
  logic [CW-1:0] col_reg, col_next;
  logic [KW-1:0] k_reg, k_next;

  logic start_accept;
  logic in_mac;
  logic busy;

  assign start_accept = (state_reg == S_IDLE) && bus.istart;
  assign in_mac       = (state_reg == S_MAC);
  assign busy         = (state_reg == S_MAC) || (state_reg == S_SCALE) || (state_reg == S_WB);

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_reg <= S_IDLE;
      row_reg   <= '0;
      col_reg   <= '0;
      k_reg     <= '0;
    end else begin
      state_reg <= state_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      k_reg     <= k_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    k_next     = k_reg;
    case (state_reg)
      S_IDLE: begin
        if (start_accept) begin
          state_next = S_MAC;
          row_next   = '0;
          col_next   = '0;
          k_next     = '0;
        end
      end
      S_MAC: begin
        // Without iready everything holds so the offered op stays stable.
        if (bus.iready) begin
          if (k_reg == K_LAST) begin
            state_next = S_SCALE;
          end else begin
            k_next = k_reg + KW'(1);
          end
        end
      end
      S_SCALE: begin
        k_next     = '0;
        state_next = S_WB;
      end
      S_WB: begin
        if (row_reg == ROW_LAST && col_reg == COL_LAST) begin
          state_next = S_DONE;
        end else if (col_reg == COL_LAST) begin
          col_next   = '0;
          row_next   = row_reg + RW'(1);
          state_next = S_MAC;
        end else begin
          col_next   = col_reg + CW'(1);
          state_next = S_MAC;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.orow         = row_reg;
  assign bus.ocol         = col_reg;
  assign bus.ok           = k_reg;
  assign bus.omac_valid   = in_mac;
  assign bus.oacc_clr     = in_mac && (k_reg == '0);
  assign bus.oscale_valid = (state_reg == S_SCALE);
  assign bus.owb_en       = (state_reg == S_WB);
  assign bus.obusy        = busy;
  assign bus.odone        = (state_reg == S_DONE);

`ifdef GEMM_SCHED_PERF_EN
  // Counter 0: busy cycles, counter 1: MAC cycles stalled by the datapath.
  logic [1:0] perf_inc;
  assign perf_inc[0] = busy;
  assign perf_inc[1] = in_mac && !bus.iready;

  genvar gi;
  for (gi = 0; gi < 2; gi++) begin : g_perf
    logic [31:0] perf_cnt_reg, perf_cnt_next;

    always_comb begin
      perf_cnt_next = perf_cnt_reg;
      if (start_accept) begin
        perf_cnt_next = '0;
      end else if (perf_inc[gi] && (perf_cnt_reg != 32'hFFFF_FFFF)) begin
        perf_cnt_next = perf_cnt_reg + 32'd1;
      end
    end

    always_ff @(posedge iclk) begin
      if (irst) begin
        perf_cnt_reg <= '0;
      end else begin
        perf_cnt_reg <= perf_cnt_next;
      end
    end
  end

  assign bus.operf_cycles = g_perf[0].perf_cnt_reg;
  assign bus.operf_stalls = g_perf[1].perf_cnt_reg;
`else
  assign bus.operf_cycles = '0;
  assign bus.operf_stalls = '0;
`endif

endmodule
